// File: rtl/ahb_apb_bridge_p_if.sv
// AHB-Lite slave / APB4 master bus bundle for ahb_apb_bridge_p.
// The "slave" modport is the bridge's view. It receives AHB and drives APB.
// The "master" modport is the environment's view. It drives AHB and answers APB.
interface ahb_apb_bridge_p_if #(
  parameter int NUM_SLOTS  = 16,
  parameter int ADDR_WIDTH = 32
);
  // AHB side
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [31:0]           HWDATA;
  logic                  HREADYIN;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [31:0]           HRDATA;
  // APB side
  logic [NUM_SLOTS-1:0]  PSEL;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic                  PENABLE;
  logic [31:0]           PWDATA;
  logic [3:0]            PSTRB;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
    input  PRDATA, PREADY, PSLVERR,
    output HREADYOUT, HRESP, HRDATA,
    output PSEL, PADDR, PWRITE, PENABLE, PWDATA, PSTRB
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
    output PRDATA, PREADY, PSLVERR,
    input  HREADYOUT, HRESP, HRDATA,
    input  PSEL, PADDR, PWRITE, PENABLE, PWDATA, PSTRB
  );
endinterface

// File: rtl/ahb_apb_bridge_p.sv
// AHB-Lite to APB4 bridge with slot decode and a two-cycle AHB error response.
// Optional feature: define AHB_APB_BRIDGE_P_TIMEOUT_EN to enable the ACCESS-phase
// timeout. When it is enabled and PREADY stays low for TIMEOUT_CYCLES cycles,
// the bridge abandons the APB transfer and returns an AHB error.
module ahb_apb_bridge_p #(
  parameter int NUM_SLOTS      = 16,
  parameter int SLOT_LSB       = 24,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 HCLK,
  input  logic                 HRESETN,
  ahb_apb_bridge_p_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [3:0]            slot_q, slot_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic [31:0]           pwdata_q, pwdata_d;

  // Control outputs from the FSM output process
  logic hreadyout;
  logic hresp;
  logic psel_en;
  logic penable;

  // Transfer-request decode
  logic       accept;
  logic [3:0] haddr_slot;
  logic       slot_ok;
  logic       timeout_hit;
  logic [3:0] strb_calc;

  assign haddr_slot = bus.HADDR[SLOT_LSB+3:SLOT_LSB];
  assign slot_ok    = ({1'b0, haddr_slot} < 5'(NUM_SLOTS));
  // A new transfer is accepted only when the bridge is ready this cycle.
  // That happens in IDLE, in ERR2, and in an ACCESS cycle that completes OK.
  assign accept     = bus.HSEL & bus.HREADYIN & bus.HTRANS[1] & hreadyout;

`ifdef AHB_APB_BRIDGE_P_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  // The counter holds the number of ACCESS cycles already spent waiting.
  // The limit is reached on the last permitted cycle.
  assign timeout_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Count ACCESS cycles. Restart whenever a new transfer enters SETUP.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d == ST_SETUP)
      tmo_cnt_d = 16'd0;
    else if (state_q == ST_ACCESS)
      tmo_cnt_d = tmo_cnt_q + 16'd1;
  end

  // Timeout counter register
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) tmo_cnt_q <= 16'd0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Byte strobes for the captured transfer. Reads never assert strobes.
  always_comb begin
    strb_calc = 4'b0000;
    if (bus.HWRITE) begin
      case (bus.HSIZE)
        3'd0:    strb_calc = 4'b0001 << bus.HADDR[1:0];
        3'd1:    strb_calc = 4'b0011 << {bus.HADDR[1], 1'b0};
        default: strb_calc = 4'b1111;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept) state_d = slot_ok ? ST_SETUP : ST_ERR1;
        else        state_d = ST_IDLE;
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.PREADY) begin
          if (bus.PSLVERR)  state_d = ST_ERR1;
          else if (accept)  state_d = slot_ok ? ST_SETUP : ST_ERR1;
          else              state_d = ST_IDLE;
        end else if (timeout_hit) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1:   state_d = ST_ERR2;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. HREADYOUT completes an OK ACCESS in the same cycle.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    psel_en   = 1'b0;
    penable   = 1'b0;
    case (state_q)
      ST_SETUP: begin
        hreadyout = 1'b0;
        psel_en   = 1'b1;
      end
      ST_ACCESS: begin
        psel_en   = 1'b1;
        penable   = 1'b1;
        hreadyout = bus.PREADY & ~bus.PSLVERR;
      end
      ST_ERR1: begin
        hresp     = 1'b1;
        hreadyout = 1'b0;
      end
      ST_ERR2: begin
        hresp     = 1'b1;
        hreadyout = 1'b1;
      end
      default: ;
    endcase
  end

  // Address-phase capture on acceptance. Write data is captured at the end of SETUP.
  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    slot_d   = slot_q;
    pstrb_d  = pstrb_q;
    pwdata_d = pwdata_q;
    if (accept) begin
      paddr_d  = bus.HADDR;
      pwrite_d = bus.HWRITE;
      slot_d   = haddr_slot;
      pstrb_d  = strb_calc;
    end
    if (state_q == ST_SETUP)
      pwdata_d = bus.HWDATA;
  end

  // APB datapath registers
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      slot_q   <= 4'd0;
      pstrb_q  <= 4'b0000;
      pwdata_q <= 32'd0;
    end else begin
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      slot_q   <= slot_d;
      pstrb_q  <= pstrb_d;
      pwdata_q <= pwdata_d;
    end
  end

  // One-hot slot select, active only while an APB transfer is in flight
  logic [NUM_SLOTS-1:0] psel_vec;
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_psel
    assign psel_vec[gi] = psel_en & (slot_q == 4'(gi));
  end

  assign bus.PSEL      = psel_vec;
  assign bus.PENABLE   = penable;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PSTRB     = pstrb_q;
  // In SETUP the write data passes straight through. After SETUP it comes from the register.
  assign bus.PWDATA    = (state_q == ST_SETUP) ? bus.HWDATA : pwdata_q;
  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = bus.PRDATA;

endmodule

// File: tb/tb_ahb_apb_bridge_p.sv
// Directed testbench for ahb_apb_bridge_p (NUM_SLOTS=4, SLOT_LSB=24, TIMEOUT_CYCLES=8).
// The timeout steps run only when AHB_APB_BRIDGE_P_TIMEOUT_EN is defined.
module tb_ahb_apb_bridge_p;

  logic HCLK;
  logic HRESETN;
  int   checks   = 0;
  int   failures = 0;

  ahb_apb_bridge_p_if #(.NUM_SLOTS(4), .ADDR_WIDTH(32)) bus ();

  ahb_apb_bridge_p #(
    .NUM_SLOTS(4), .SLOT_LSB(24), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK    (HCLK),
    .HRESETN (HRESETN),
    .bus     (bus)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
    end
    $display("check %-16s observed=0x%08h expected=0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = a;
    bus.HWRITE = w;
    bus.HSIZE  = sz;
  endtask

  task automatic idle_bus();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
  endtask

  initial begin
    HRESETN      = 1'b0;
    bus.HSEL     = 1'b0;
    bus.HADDR    = 32'd0;
    bus.HTRANS   = 2'b00;
    bus.HWRITE   = 1'b0;
    bus.HSIZE    = 3'd0;
    bus.HWDATA   = 32'd0;
    bus.HREADYIN = 1'b1;
    bus.PRDATA   = 32'd0;
    bus.PREADY   = 1'b0;
    bus.PSLVERR  = 1'b0;

    // Reset state
    #2;
    check("rst_hready", 32'(bus.HREADYOUT), 32'd1);
    check("rst_hresp",  32'(bus.HRESP),     32'd0);
    check("rst_psel",   32'(bus.PSEL),      32'd0);
    check("rst_penable",32'(bus.PENABLE),   32'd0);
    check("rst_paddr",  bus.PADDR,          32'd0);
    check("rst_pstrb",  32'(bus.PSTRB),     32'd0);
    #10;
    HRESETN = 1'b1;

    // Word write to slot 2, zero-wait
    addr_phase(32'h0200_0010, 1'b1, 3'd2);
    #1 check("wr_idle_ready", 32'(bus.HREADYOUT), 32'd1);
    tick();
    idle_bus();
    bus.HWDATA = 32'hDEAD_BEEF;
    bus.PREADY = 1'b1;
    #1;
    check("wr_setup_psel",   32'(bus.PSEL),      32'h4);
    check("wr_setup_pen",    32'(bus.PENABLE),   32'd0);
    check("wr_setup_hrdy",   32'(bus.HREADYOUT), 32'd0);
    check("wr_setup_pwdata", bus.PWDATA,         32'hDEAD_BEEF);
    check("wr_setup_pstrb",  32'(bus.PSTRB),     32'hF);
    check("wr_setup_paddr",  bus.PADDR,          32'h0200_0010);
    check("wr_setup_pwrite", 32'(bus.PWRITE),    32'd1);
    tick();
    bus.HWDATA = 32'd0;
    #1;
    check("wr_acc_pen",    32'(bus.PENABLE),   32'd1);
    check("wr_acc_psel",   32'(bus.PSEL),      32'h4);
    check("wr_acc_pwdata", bus.PWDATA,         32'hDEAD_BEEF);
    check("wr_acc_hrdy",   32'(bus.HREADYOUT), 32'd1);
    tick();
    check("wr_done_psel",  32'(bus.PSEL),      32'd0);
    check("wr_done_hrdy",  32'(bus.HREADYOUT), 32'd1);

    // Read from slot 1 with three wait cycles, then back-to-back byte write
    addr_phase(32'h0100_0004, 1'b0, 3'd2);
    tick();
    idle_bus();
    bus.PREADY = 1'b0;
    #1;
    check("rd_setup_psel",  32'(bus.PSEL),      32'h2);
    check("rd_setup_pstrb", 32'(bus.PSTRB),     32'h0);
    check("rd_setup_pwr",   32'(bus.PWRITE),    32'd0);
    check("rd_setup_hrdy",  32'(bus.HREADYOUT), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_wait_pen",  32'(bus.PENABLE),   32'd1);
      check("rd_wait_hrdy", 32'(bus.HREADYOUT), 32'd0);
    end
    tick();
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h1234_5678;
    addr_phase(32'h0000_0003, 1'b1, 3'd0);
    #1;
    check("rd_done_hrdy",  32'(bus.HREADYOUT), 32'd1);
    check("rd_done_hrdata",bus.HRDATA,         32'h1234_5678);
    tick();
    idle_bus();
    bus.HWDATA  = 32'hAA00_0000;
    bus.PSLVERR = 1'b1;
    #1;
    check("b2b_setup_psel",  32'(bus.PSEL),    32'h1);
    check("b2b_setup_pstrb", 32'(bus.PSTRB),   32'h8);
    check("b2b_setup_pen",   32'(bus.PENABLE), 32'd0);
    tick();
    check("slverr_acc_hrdy", 32'(bus.HREADYOUT), 32'd0);
    check("slverr_acc_hresp",32'(bus.HRESP),     32'd0);
    tick();
    bus.PSLVERR = 1'b0;
    bus.PREADY  = 1'b0;
    #1;
    check("slverr_e1_hresp", 32'(bus.HRESP),     32'd1);
    check("slverr_e1_hrdy",  32'(bus.HREADYOUT), 32'd0);
    check("slverr_e1_psel",  32'(bus.PSEL),      32'd0);
    check("slverr_e1_pen",   32'(bus.PENABLE),   32'd0);
    tick();
    check("slverr_e2_hresp", 32'(bus.HRESP),     32'd1);
    check("slverr_e2_hrdy",  32'(bus.HREADYOUT), 32'd1);

    // Accepted during ERR2: slot 5 does not exist, so an error is returned and no slot is selected
    addr_phase(32'h0500_0000, 1'b0, 3'd2);
    tick();
    idle_bus();
    #1;
    check("bad_e1_hresp", 32'(bus.HRESP),     32'd1);
    check("bad_e1_hrdy",  32'(bus.HREADYOUT), 32'd0);
    check("bad_e1_psel",  32'(bus.PSEL),      32'd0);
    tick();
    check("bad_e2_hresp", 32'(bus.HRESP),     32'd1);
    check("bad_e2_hrdy",  32'(bus.HREADYOUT), 32'd1);
    check("bad_e2_psel",  32'(bus.PSEL),      32'd0);
    tick();
    check("bad_idle_hresp", 32'(bus.HRESP),     32'd0);
    check("bad_idle_hrdy",  32'(bus.HREADYOUT), 32'd1);

    // Halfword write to the upper half
    addr_phase(32'h0000_0002, 1'b1, 3'd1);
    tick();
    idle_bus();
    bus.HWDATA = 32'h5555_0000;
    bus.PREADY = 1'b1;
    #1;
    check("half_pstrb", 32'(bus.PSTRB), 32'hC);
    check("half_psel",  32'(bus.PSEL),  32'h1);
    tick();
    check("half_acc_hrdy", 32'(bus.HREADYOUT), 32'd1);
    tick();

`ifdef AHB_APB_BRIDGE_P_TIMEOUT_EN
    // Timeout: PREADY is held low
    addr_phase(32'h0300_0000, 1'b1, 3'd2);
    tick();
    idle_bus();
    bus.PREADY = 1'b0;
    #1;
    check("tmo_setup_psel", 32'(bus.PSEL), 32'h8);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("tmo_acc_pen",  32'(bus.PENABLE),   32'd1);
      check("tmo_acc_hrdy", 32'(bus.HREADYOUT), 32'd0);
    end
    tick();
    check("tmo_e1_pen",   32'(bus.PENABLE),   32'd0);
    check("tmo_e1_psel",  32'(bus.PSEL),      32'd0);
    check("tmo_e1_hresp", 32'(bus.HRESP),     32'd1);
    check("tmo_e1_hrdy",  32'(bus.HREADYOUT), 32'd0);
    tick();
    check("tmo_e2_hresp", 32'(bus.HRESP),     32'd1);
    check("tmo_e2_hrdy",  32'(bus.HREADYOUT), 32'd1);
    tick();
`endif

    // Stalled ACCESS, then asynchronous reset in the middle of the cycle
    addr_phase(32'h0300_0008, 1'b1, 3'd2);
    tick();
    idle_bus();
    bus.HWDATA = 32'h0BAD_F00D;
    bus.PREADY = 1'b0;
    tick();
`ifdef AHB_APB_BRIDGE_P_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
`else
    for (int i = 0; i < 20; i++) begin
`endif
      check("stall_hrdy", 32'(bus.HREADYOUT), 32'd0);
      check("stall_pen",  32'(bus.PENABLE),   32'd1);
      tick();
    end
    #2;
    HRESETN = 1'b0;
    #1;
    check("arst_psel",   32'(bus.PSEL),      32'd0);
    check("arst_pen",    32'(bus.PENABLE),   32'd0);
    check("arst_hrdy",   32'(bus.HREADYOUT), 32'd1);
    check("arst_hresp",  32'(bus.HRESP),     32'd0);
    check("arst_paddr",  bus.PADDR,          32'd0);
    check("arst_pwrite", 32'(bus.PWRITE),    32'd0);
    check("arst_pwdata", bus.PWDATA,         32'd0);
    check("arst_pstrb",  32'(bus.PSTRB),     32'd0);
    tick();
    HRESETN = 1'b1;

    // First transfer after reset is accepted immediately
    addr_phase(32'h0100_0000, 1'b0, 3'd2);
    tick();
    idle_bus();
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hCAFE_F00D;
    #1;
    check("post_setup_psel", 32'(bus.PSEL), 32'h2);
    tick();
    check("post_acc_hrdy",   32'(bus.HREADYOUT), 32'd1);
    check("post_acc_hrdata", bus.HRDATA,         32'hCAFE_F00D);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stuck simulation
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ahb_apb_bridge_p.md
AHB_APB_BRIDGE_P -- requirements
Module: ahb_apb_bridge_p

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 16, number of APB slots (1..16).
REQ-002 SHALL have parameter SLOT_LSB, default 24, LSB of the 4-bit slot field HADDR[SLOT_LSB+3:SLOT_LSB].
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, width of HADDR/PADDR (>= SLOT_LSB+4).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS cycles before timeout (1..65535).
REQ-005 HCLK  in  1  single clock; all logic on rising edge.
REQ-006 HRESETN  in  1  reset, asynchronous, active-low.
REQ-007 HSEL  in  1  bridge selected.
REQ-008 HADDR  in  ADDR_WIDTH  AHB address.
REQ-009 HTRANS  in  2  transfer type; bit1=1 is NONSEQ/SEQ.
REQ-010 HWRITE  in  1  write when 1.
REQ-011 HSIZE  in  3  transfer size (0=byte, 1=half, 2=word).
REQ-012 HWDATA  in  32  write data, valid in data phase.
REQ-013 HREADYIN  in  1  AHB bus ready.
REQ-014 HREADYOUT  out  1  bridge ready.
REQ-015 HRESP  out  1  1=ERROR.
REQ-016 HRDATA  out  32  read data, equals PRDATA.
REQ-017 PSEL  out  NUM_SLOTS  one-hot slot select.
REQ-018 PADDR  out  ADDR_WIDTH  registered address.
REQ-019 PWRITE  out  1  registered direction.
REQ-020 PENABLE  out  1  APB access phase.
REQ-021 PWDATA  out  32  write data.
REQ-022 PSTRB  out  4  byte strobes, APB4.
REQ-023 PRDATA  in  32  read data.
REQ-024 PREADY  in  1  slave ready.
REQ-025 PSLVERR  in  1  slave error, sampled only with PREADY in ACCESS.

Function
REQ-026 Accept: HSEL & HREADYIN & HTRANS[1] & HREADYOUT at a rising edge, in IDLE, ERR2, or ACCESS-completing-OK; capture HADDR, HWRITE, HSIZE.
REQ-027 States: IDLE, SETUP, ACCESS, ERR1, ERR2; unaccepted cycles in IDLE/ERR2 -> IDLE.
REQ-028 Accept with slot field < NUM_SLOTS -> SETUP; slot field >= NUM_SLOTS -> ERR1, no PSEL ever asserted.
REQ-029 SETUP: PSEL[slot]=1, PENABLE=0, HREADYOUT=0, PWDATA=HWDATA (combinational), HWDATA registered at end of SETUP; next ACCESS.
REQ-030 ACCESS: PSEL held, PENABLE=1, PWDATA from register, all P outputs stable until PREADY.
REQ-031 ACCESS & PREADY & !PSLVERR: HREADYOUT=1 same cycle (combinational), HRDATA=PRDATA; next IDLE, or SETUP if new transfer accepted (zero-bubble back-to-back).
REQ-032 ACCESS & PREADY & PSLVERR: PSEL/PENABLE drop next cycle; -> ERR1.
REQ-033 ERR1: HRESP=1, HREADYOUT=0; ERR2: HRESP=1, HREADYOUT=1 (two-cycle AHB error).
REQ-034 PSTRB writes: HSIZE=0 -> 1<<HADDR[1:0]; HSIZE=1 -> 4'b0011<<{HADDR[1],1'b0}; HSIZE>=2 -> 4'b1111; reads -> 4'b0000.
REQ-035 IDLE: HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0.

Reset
REQ-036 HRESETN low: state IDLE immediately; HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, timeout counter=0; in-flight APB transfer abandoned without AHB response.
REQ-037 First acceptance possible at first rising edge with HRESETN high.

Configuration
REQ-038 Macro AHB_APB_BRIDGE_P_TIMEOUT_EN defined: counter counts ACCESS cycles; PREADY low for TIMEOUT_CYCLES consecutive ACCESS cycles -> drop PSEL/PENABLE, go ERR1; counter clears on entering SETUP.
REQ-039 Macro undefined: no counter logic; ACCESS waits indefinitely for PREADY.

Verification
REQ-040 NUM_SLOTS=4, SLOT_LSB=24: write 0x0200_0010, HSIZE=2, HWDATA=0xDEADBEEF, PREADY=1 -> PSEL=4'b0100, PSTRB=4'hF, PWDATA=0xDEADBEEF, HREADYOUT low exactly 1 cycle.
REQ-041 Read 0x0100_0004, PREADY low 3 ACCESS cycles, PRDATA=0x1234_5678 -> HREADYOUT high only on 4th ACCESS cycle, HRDATA=0x1234_5678.
REQ-042 Address 0x0500_0000 (slot 5 >= 4) -> PSEL stays 0, HRESP=1 two cycles, HREADYOUT 0 then 1.
REQ-043 PSLVERR=1 with PREADY -> ERR1/ERR2 sequence; byte write to 0x0000_0003 -> PSTRB=4'b1000.
REQ-044 Macro on, TIMEOUT_CYCLES=8, PREADY tied 0 -> PENABLE high 8 cycles, then HRESP two-cycle error; macro off -> HREADYOUT stays 0.
REQ-045 HRESETN low during ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1 without waiting for HCLK.
